paddle_to_quad: RTL and testbench

//  Converts an absolute 8-bit paddle/spinner position from hps_io into a rate-limited

---
 rtl/paddle_to_quad.sv | 135 +++++++++++++
 tb/tb_paddle_to_quad.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/paddle_to_quad.sv
// Absolute paddle position to rate-limited quadrature steering for the Sprint2 core.
// Optional PADDLE_QUAD_ACCEL_EN: halve the step period while |pending| >= 64.
module paddle_to_quad #(
  parameter int STEP_DIV  = 22500,
  parameter int PEND_W    = 10,
  parameter int DEAD_ZONE = 2
) (
  input  logic       CLK,
  input  logic       reset,
  input  logic [7:0] pos_in,
  input  logic       pos_valid,
  output logic [1:0] steer,
  output logic       dir,
  output logic       busy
);

  localparam int DIV_W = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
  // Two guard bits so pending + delta - 1 never overflows before saturation.
  localparam int ACC_W = PEND_W + 2;
  localparam logic signed [ACC_W-1:0] PEND_MAX = ACC_W'(2 ** (PEND_W - 1) - 1);
  localparam logic signed [ACC_W-1:0] PEND_MIN = -PEND_MAX;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(STEP_DIV - 1);
  localparam logic [7:0] DZ = 8'(DEAD_ZONE);

  localparam logic [0:0] S_INIT  = 1'b0;
  localparam logic [0:0] S_TRACK = 1'b1;

  logic [0:0]               state_q, state_d;
  logic [7:0]               last_q, last_d;
  logic signed [PEND_W-1:0] pend_q, pend_d;
  logic [DIV_W-1:0]         div_q, div_d;
  logic [1:0]               steer_q, steer_d;
  logic                     dir_q, dir_d;
  logic                     busy_q, busy_d;

  logic signed [7:0]        delta;
  logic [7:0]               mag;
  logic                     take;
  logic                     tc;
  logic signed [ACC_W-1:0]  sum;

  function automatic logic signed [PEND_W-1:0] sat_pend(input logic signed [ACC_W-1:0] v);
    if (v > PEND_MAX)      return PEND_MAX[PEND_W-1:0];
    else if (v < PEND_MIN) return PEND_MIN[PEND_W-1:0];
    else                   return v[PEND_W-1:0];
  endfunction

  function automatic logic [1:0] phase_fwd(input logic [1:0] p);
    case (p)
      2'b00:   return 2'b01;
      2'b01:   return 2'b11;
      2'b11:   return 2'b10;
      default: return 2'b00;
    endcase
  endfunction

  function automatic logic [1:0] phase_rev(input logic [1:0] p);
    case (p)
      2'b00:   return 2'b10;
      2'b10:   return 2'b11;
      2'b11:   return 2'b01;
      default: return 2'b00;
    endcase
  endfunction

  // Modular 8-bit difference: the wheel wrapping 255->0 reads as a small step.
  assign delta = signed'(pos_in - last_q);
  assign mag   = delta[7] ? 8'(-delta) : 8'(delta);
  assign take  = pos_valid && (state_q == S_TRACK) && (mag >= DZ);
  assign tc    = (div_q == DIV_LAST);

  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    div_d   = div_q + 1'b1;
    steer_d = steer_q;
    dir_d   = dir_q;
    sum     = {{2{pend_q[PEND_W-1]}}, pend_q};

    if (state_q == S_INIT && pos_valid) begin
      state_d = S_TRACK;
      last_d  = pos_in;
    end

    // Sub-dead-zone samples leave last_pos alone so slow drift still accumulates.
    if (take) begin
      sum    = sum + {{(ACC_W-8){delta[7]}}, delta};
      last_d = pos_in;
    end

    if (tc) begin
      div_d = '0;
      if (pend_q > 0) begin
        steer_d = phase_fwd(steer_q);
        dir_d   = 1'b1;
        sum     = sum - ACC_W'(1);
      end else if (pend_q < 0) begin
        steer_d = phase_rev(steer_q);
        dir_d   = 1'b0;
        sum     = sum + ACC_W'(1);
      end
`ifdef PADDLE_QUAD_ACCEL_EN
      if (pend_q >= 64 || pend_q <= -64) div_d = DIV_W'(STEP_DIV / 2);
`else
`endif
    end

    pend_d = sat_pend(sum);
    busy_d = (pend_d != '0);
  end

  always_ff @(posedge CLK) begin
    if (reset) begin
      state_q <= S_INIT;
      pend_q  <= '0;
      div_q   <= '0;
      steer_q <= 2'b00;
      dir_q   <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pend_q  <= pend_d;
      div_q   <= div_d;
      steer_q <= steer_d;
      dir_q   <= dir_d;
      busy_q  <= busy_d;
    end
    last_q <= last_d;
  end

  assign steer = steer_q;
  assign dir   = dir_q;
  assign busy  = busy_q;

endmodule

// File: tb/tb_paddle_to_quad.sv
// Randomized and directed bench for paddle_to_quad against a behavioural step model.
module tb_paddle_to_quad;

  localparam int SD   = 16;
  localparam int PW   = 10;
  localparam int DZ   = 2;
  localparam int PMAX = 511;
`ifdef PADDLE_QUAD_ACCEL_EN
  localparam bit ACCEL = 1'b1;
`else
  localparam bit ACCEL = 1'b0;
`endif

  logic       CLK = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] pos_in = 8'd0;
  logic       pos_valid = 1'b0;
  logic [1:0] steer;
  logic       dir;
  logic       busy;

  paddle_to_quad #(.STEP_DIV(SD), .PEND_W(PW), .DEAD_ZONE(DZ)) dut (
    .CLK(CLK), .reset(reset), .pos_in(pos_in), .pos_valid(pos_valid),
    .steer(steer), .dir(dir), .busy(busy)
  );

  always #5 CLK = ~CLK;

  int n_checks = 0;
  int n_errors = 0;
  int edges = 0;
  logic [1:0] prev_steer = 2'b00;

  // Model: phase is a position 0..3 on the forward Gray cycle 00,01,11,10.
  int steer_tab[4] = '{0, 1, 3, 2};
  bit m_init = 1'b1;
  int m_last = 0;
  int m_pend = 0;
  int m_ph = 0;
  int m_dir = 0;
  int m_div = 0;

  task automatic chk(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_step(input bit v, input int p, input bit r);
    int d, np, a;
    bit tc;
    if (r) begin
      m_init = 1'b1; m_pend = 0; m_ph = 0; m_dir = 0; m_div = 0;
    end else begin
      tc = (m_div == SD - 1);
      d = 0;
      if (v) begin
        if (m_init) begin
          m_last = p; m_init = 1'b0;
        end else begin
          d = p - m_last;
          if (d > 127) d -= 256;
          else if (d < -128) d += 256;
          a = (d < 0) ? -d : d;
          if (a >= DZ) m_last = p;
          else d = 0;
        end
      end
      np = m_pend + d;
      if (tc) begin
        if (m_pend > 0) begin
          m_ph = (m_ph + 1) % 4; np -= 1; m_dir = 1;
        end else if (m_pend < 0) begin
          m_ph = (m_ph + 3) % 4; np += 1; m_dir = 0;
        end
        a = (m_pend < 0) ? -m_pend : m_pend;
        m_div = (ACCEL && a >= 64) ? SD / 2 : 0;
      end else begin
        m_div++;
      end
      if (np > PMAX) np = PMAX;
      if (np < -PMAX) np = -PMAX;
      m_pend = np;
    end
  endtask

  task automatic tick(input bit v, input int p, input bit r);
    pos_valid = v;
    pos_in = 8'(p & 255);
    reset = r;
    @(posedge CLK);
    model_step(v, p & 255, r);
    #1;
    chk("steer", int'(steer), steer_tab[m_ph]);
    chk("dir", int'(dir), m_dir);
    chk("busy", int'(busy), (m_pend != 0) ? 1 : 0);
    if (steer != prev_steer) edges++;
    prev_steer = steer;
    @(negedge CLK);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick(1'b0, 0, 1'b0);
  endtask

  int p;
  int rpos;

  initial begin
    // T1: INIT load then +5 -> five forward edges
    tick(1'b0, 0, 1'b1);
    tick(1'b0, 0, 1'b0);
    tick(1'b1, 100, 1'b0);
    tick(1'b1, 105, 1'b0);
    edges = 0;
    idle(5 * SD + 8);
    chk("t1_edges", edges, 5);

    // T2: -9 reverse, then +7 across the wrap
    tick(1'b0, 0, 1'b1);
    tick(1'b1, 3, 1'b0);
    edges = 0;
    tick(1'b1, 250, 1'b0);
    idle(9 * SD + 16);
    chk("t2_rev_edges", edges, 9);
    edges = 0;
    tick(1'b1, 1, 1'b0);
    idle(7 * SD + 16);
    chk("t2_wrap_edges", edges, 7);

    // T3: dead zone
    tick(1'b0, 0, 1'b1);
    tick(1'b1, 50, 1'b0);
    edges = 0;
    tick(1'b1, 51, 1'b0);
    tick(1'b1, 52, 1'b0);
    idle(3 * SD + 16);
    chk("t3_edges", edges, 2);

    // T4: delta arriving on the tc cycle with pending=+3
    tick(1'b0, 0, 1'b1);
    tick(1'b1, 100, 1'b0);
    tick(1'b1, 103, 1'b0);
    for (int i = 0; i < 2 * SD && m_div != SD - 1; i++) tick(1'b0, 0, 1'b0);
    edges = 0;
    tick(1'b1, 93, 1'b0);
    idle(9 * SD + 8);
    chk("t4_edges", edges, 9);

    // T5: saturation both ways and the -128 delta
    tick(1'b0, 0, 1'b1);
    p = 0;
    tick(1'b1, p, 1'b0);
    for (int i = 0; i < 10; i++) begin p += 127; tick(1'b1, p, 1'b0); end
    idle(200);
    for (int i = 0; i < 20; i++) begin p -= 127; tick(1'b1, p, 1'b0); end
    idle(200);
    p += 128;
    tick(1'b1, p, 1'b0);
    idle(100);

    // T6: reset mid-sequence with steer=11
    tick(1'b0, 0, 1'b1);
    tick(1'b1, 0, 1'b0);
    tick(1'b1, 20, 1'b0);
    for (int i = 0; i < 4 * SD && m_ph != 2; i++) tick(1'b0, 0, 1'b0);
    chk("t6_pre_steer", int'(steer), 3);
    tick(1'b0, 0, 1'b1);
    tick(1'b1, 77, 1'b0);
    edges = 0;
    idle(3 * SD);
    chk("t6_edges", edges, 0);

    // Random: jitter, fast spins, sparse resets
    rpos = 128;
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 2) == 0) rpos += $urandom_range(0, 120) - 60;
      else rpos += $urandom_range(0, 6) - 3;
      tick(($urandom_range(0, 3) == 0), rpos & 255, ($urandom_range(0, 799) == 0));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
